// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM states and default latencies for the HI/LO multiply/divide unit.
package md_pkg;
    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_DIV   = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_NONE  = 4'd15;
    typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_e;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational MULT/MULTU/DIV/DIVU result generator for the latched op and operands.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_zero
);
    logic               ovf;
    logic [31:0]        b_safe, q_u, r_u;
    logic signed [31:0] q_s, r_s;
    logic [63:0]        prod_s, prod_u;
    always_comb begin
        div_zero = (op == MD_DIV || op == MD_DIVU) && b == '0;
        // INT_MIN / -1 has a fixed result; keep the divider away from the overflow and zero cases
        ovf      = op == MD_DIV && a == 32'h8000_0000 && b == '1;
        b_safe   = (div_zero || ovf) ? 32'd1 : b;
        q_u      = a / b_safe;
        r_u      = a % b_safe;
        q_s      = $signed(a) / $signed(b_safe);
        r_s      = $signed(a) % $signed(b_safe);
        prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u   = {32'd0, a} * {32'd0, b};
        {hi_res, lo_res} = op == MD_MULT  ? prod_s :
                           op == MD_MULTU ? prod_u :
                           op == MD_DIVU  ? {r_u, q_u} :
                           ovf            ? {32'd0, 32'h8000_0000} : {r_s, q_s};
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage HI/LO unit, fixed-latency MULT/DIV plus single-cycle MTHI/MTLO.
// Define MD_CANCEL_EN to add md_cancel, which kills the op issued in the previous cycle.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_ctrl,
    input  logic        issue_en,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hilo_sel,
`ifdef MD_CANCEL_EN
    input  logic        md_cancel,
`endif
    output logic        start,
    output logic        busy,
    output logic [31:0] hilo_out
);
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, hi_res, lo_res;
    logic        busy_q, busy_d, div_zero, mt_go, done, kill;
`ifdef MD_CANCEL_EN
    logic        issued_q, issued_d;
    logic [1:0]  mt_q, mt_d;
    logic [31:0] shadow_q, shadow_d;
`endif
    md_arith u_arith (
        .op(op_q), .a(a_q), .b(b_q), .hi_res(hi_res), .lo_res(lo_res), .div_zero(div_zero)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= MD_NONE;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
`ifdef MD_CANCEL_EN
            issued_q <= 1'b0;
            mt_q     <= '0;
            shadow_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
`ifdef MD_CANCEL_EN
            issued_q <= issued_d;
            mt_q     <= mt_d;
            shadow_q <= shadow_d;
`endif
        end
    end
    always_comb begin
        state_d = start ? (md_ctrl[0] ? RUN_DIV : RUN_MUL) : (done || kill) ? IDLE : state_q;
        cnt_d   = start ? (md_ctrl[0] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) :
                  (done || kill) ? 4'd0 :
                  state_q != IDLE ? cnt_q - 4'd1 : cnt_q;
        op_d    = start ? md_ctrl : op_q;
        a_d     = start ? src_a : a_q;
        b_d     = start ? src_b : b_q;
        busy_d  = state_d != IDLE;
    end
    always_comb begin
        start = issue_en && state_q == IDLE && md_ctrl <= MD_DIVU;
        mt_go = issue_en && state_q == IDLE && (md_ctrl == MD_MTHI || md_ctrl == MD_MTLO);
        done  = state_q != IDLE && cnt_q == 4'd1;
`ifdef MD_CANCEL_EN
        kill  = md_cancel && issued_q;
`else
        kill  = 1'b0;
`endif
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (done && !kill && !div_zero) {hi_d, lo_d} = {hi_res, lo_res};
`ifdef MD_CANCEL_EN
        // a cancelled MTHI/MTLO rolls back to the value captured when it issued
        if (md_cancel && mt_q[1]) hi_d = shadow_q;
        if (md_cancel && mt_q[0]) lo_d = shadow_q;
        mt_d     = {mt_go && md_ctrl == MD_MTHI, mt_go && md_ctrl == MD_MTLO};
        shadow_d = mt_go ? (md_ctrl == MD_MTHI ? hi_q : lo_q) : shadow_q;
        issued_d = start;
`endif
        if (mt_go && md_ctrl == MD_MTHI) hi_d = src_a;
        if (mt_go && md_ctrl == MD_MTLO) lo_d = src_a;
        busy     = busy_q;
        hilo_out = hilo_sel ? lo_q : hi_q;
    end
endmodule
